// File: rtl/trg_tx_link_ctrl_if.sv
// Handshake bundle between the TX link bring-up controller and the GTX
// transmitter it supervises. The controller side uses the master modport;
// the transmitter side (or a testbench standing in for it) uses slave.
interface trg_tx_link_ctrl_if;
  // Status coming back from the transmitter and the link manager
  logic       trg_tx_pll_lock;
  logic       trg_txresetdone;
  logic       tx_sync_done;
  logic       link_restart;

  // Controls and status produced by the controller
  logic       trg_tx_pllrst;
  logic       trg_gtxtxrst;
  logic       trg_rst;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] retry_cnt;
  logic       timeout_err;

  modport master (
    input  trg_tx_pll_lock,
    input  trg_txresetdone,
    input  tx_sync_done,
    input  link_restart,
    output trg_tx_pllrst,
    output trg_gtxtxrst,
    output trg_rst,
    output link_up,
    output state,
    output retry_cnt,
    output timeout_err
  );

  modport slave (
    output trg_tx_pll_lock,
    output trg_txresetdone,
    output tx_sync_done,
    output link_restart,
    input  trg_tx_pllrst,
    input  trg_gtxtxrst,
    input  trg_rst,
    input  link_up,
    input  state,
    input  retry_cnt,
    input  timeout_err
  );
endinterface

// File: rtl/trg_tx_link_ctrl.sv
// Trigger TX link bring-up controller.
// Sequences the GTX transmitter through PLL reset, PLL lock, GTX TX reset,
// reset-done, phase alignment and an idle-comma period before declaring the
// link up. Any loss of lock (or of reset-done once up), a stuck wait state, or
// an external restart request sends the sequence back to the PLL reset and
// bumps a saturating retry counter.
module trg_tx_link_ctrl #(
  parameter int PLLRST_CYCLES = 8,
  parameter int GTXRST_CYCLES = 8,
  parameter int COMMA_CYCLES  = 256,
  parameter int WAIT_TIMEOUT  = 65535
) (
  input  logic               trg_clk80,
  input  logic               rst,
  trg_tx_link_ctrl_if.master link
);

  typedef enum logic [2:0] {
    PLL_RST      = 3'd0,
    PLL_WAIT     = 3'd1,
    GTX_RST      = 3'd2,
    RSTDONE_WAIT = 3'd3,
    SYNC_WAIT    = 3'd4,
    COMMA        = 3'd5,
    UP           = 3'd6
  } state_t;

  // Timer values on the last cycle of each timed state. The timer reads 0 on
  // the first cycle of a state, so leaving when it reaches N-1 gives exactly
  // N cycles in that state.
  localparam logic [15:0] PLLRST_LAST  = 16'(PLLRST_CYCLES - 1);
  localparam logic [15:0] GTXRST_LAST  = 16'(GTXRST_CYCLES - 1);
  localparam logic [15:0] COMMA_LAST   = 16'(COMMA_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(WAIT_TIMEOUT - 1);

  logic        lock_meta;
  logic        lock_sync;
  logic        rstdone_meta;
  logic        rstdone_sync;

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic [7:0]  retry_cnt;

  logic        in_wait;
  logic        lock_lost;
  logic        rstdone_lost;
  logic        exit_now;
  logic        timer_clear;
  logic        retry_inc;
  logic        timeout_hit;

  logic        pllrst_q;
  logic        gtxtxrst_q;
  logic        trg_rst_q;
  logic        link_up_q;
  logic        timeout_err_q;

  // Bring the transceiver's lock and reset-done flags into the TRG_CLK80
  // domain; the FSM only ever looks at the second flop of each pair.
  always_ff @(posedge trg_clk80 or posedge rst) begin
    if (rst) begin
      lock_meta    <= 1'b0;
      lock_sync    <= 1'b0;
      rstdone_meta <= 1'b0;
      rstdone_sync <= 1'b0;
    end else begin
      lock_meta    <= link.trg_tx_pll_lock;
      lock_sync    <= lock_meta;
      rstdone_meta <= link.trg_txresetdone;
      rstdone_sync <= rstdone_meta;
    end
  end

  // Classify the current state and detect the fault conditions that can
  // abort the bring-up sequence.
  always_comb begin
    in_wait      = (state == PLL_WAIT) || (state == RSTDONE_WAIT) || (state == SYNC_WAIT);
    lock_lost    = !lock_sync && (state != PLL_RST) && (state != PLL_WAIT);
    rstdone_lost = !rstdone_sync && (state == UP);
  end

  // Next-state logic. Restart requests win over lock loss, which wins over a
  // wait timeout, which wins over the normal forward step. Every abort path
  // funnels into a single retry_inc so the counter moves at most once a cycle.
  always_comb begin
    state_next  = state;
    exit_now    = 1'b0;
    timer_clear = 1'b0;
    retry_inc   = 1'b0;
    timeout_hit = 1'b0;

    case (state)
      PLL_RST:      exit_now = (timer >= PLLRST_LAST);
      PLL_WAIT:     exit_now = lock_sync;
      GTX_RST:      exit_now = (timer >= GTXRST_LAST);
      RSTDONE_WAIT: exit_now = rstdone_sync;
      SYNC_WAIT:    exit_now = link.tx_sync_done;
      COMMA:        exit_now = (timer >= COMMA_LAST);
      UP:           exit_now = 1'b0;
      default:      exit_now = 1'b1;
    endcase

    if (link.link_restart) begin
      // A restart while already holding the PLL reset just stretches the
      // hold; it is not a new bring-up attempt.
      state_next  = PLL_RST;
      timer_clear = 1'b1;
      retry_inc   = (state != PLL_RST);
    end else if (lock_lost || rstdone_lost) begin
      state_next  = PLL_RST;
      timer_clear = 1'b1;
      retry_inc   = 1'b1;
    end else if (in_wait && !exit_now && (timer >= TIMEOUT_LAST)) begin
      state_next  = PLL_RST;
      timer_clear = 1'b1;
      retry_inc   = 1'b1;
      timeout_hit = 1'b1;
    end else if (exit_now) begin
      timer_clear = 1'b1;
      case (state)
        PLL_RST:      state_next = PLL_WAIT;
        PLL_WAIT:     state_next = GTX_RST;
        GTX_RST:      state_next = RSTDONE_WAIT;
        RSTDONE_WAIT: state_next = SYNC_WAIT;
        SYNC_WAIT:    state_next = COMMA;
        COMMA:        state_next = UP;
        default:      state_next = PLL_RST;
      endcase
    end
  end

  // State register.
  always_ff @(posedge trg_clk80 or posedge rst) begin
    if (rst) begin
      state <= PLL_RST;
    end else begin
      state <= state_next;
    end
  end

  // Per-state cycle timer: zero on the first cycle of every state (and on a
  // restart of the PLL reset hold), counting up otherwise.
  always_ff @(posedge trg_clk80 or posedge rst) begin
    if (rst) begin
      timer <= 16'd0;
    end else if (timer_clear) begin
      timer <= 16'd0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  // Count bring-up restarts, sticking at the top value instead of wrapping.
  always_ff @(posedge trg_clk80 or posedge rst) begin
    if (rst) begin
      retry_cnt <= 8'd0;
    end else if (retry_inc && (retry_cnt != 8'hFF)) begin
      retry_cnt <= retry_cnt + 8'd1;
    end
  end

  // Registered transmitter controls, decoded from the state being entered so
  // they line up cycle-for-cycle with the STATE output.
  always_ff @(posedge trg_clk80 or posedge rst) begin
    if (rst) begin
      pllrst_q      <= 1'b1;
      gtxtxrst_q    <= 1'b1;
      trg_rst_q     <= 1'b1;
      link_up_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pllrst_q      <= (state_next == PLL_RST);
      gtxtxrst_q    <= (state_next == PLL_RST) || (state_next == PLL_WAIT) ||
                       (state_next == GTX_RST);
      trg_rst_q     <= (state_next != UP);
      link_up_q     <= (state_next == UP);
      timeout_err_q <= timeout_hit;
    end
  end

  assign link.trg_tx_pllrst = pllrst_q;
  assign link.trg_gtxtxrst  = gtxtxrst_q;
  assign link.trg_rst       = trg_rst_q;
  assign link.link_up       = link_up_q;
  assign link.state         = state;
  assign link.retry_cnt     = retry_cnt;
  assign link.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_trg_tx_link_ctrl.sv
// Directed testbench for trg_tx_link_ctrl. Each scenario task drives the
// transceiver status lines and checks the controller outputs against values
// worked out by hand from the bring-up timing.
module tb_trg_tx_link_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks      = 0;
  int failures    = 0;
  int terr_pulses = 0;

  trg_tx_link_ctrl_if link ();

  trg_tx_link_ctrl #(
    .PLLRST_CYCLES(8),
    .GTXRST_CYCLES(8),
    .COMMA_CYCLES (256),
    .WAIT_TIMEOUT (100)
  ) dut (
    .trg_clk80(clk),
    .rst      (rst),
    .link     (link)
  );

  // 80 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Count every cycle in which the timeout pulse is seen high.
  always @(negedge clk) begin
    if (link.timeout_err === 1'b1) terr_pulses++;
  end

  // Watchdog so the run always ends even if a scenario stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected {pllrst, gtxtxrst, trg_rst, link_up} for a given state.
  function automatic logic [3:0] exp_outputs(input logic [2:0] s);
    case (s)
      3'd0:          return 4'b1110;
      3'd1, 3'd2:    return 4'b0110;
      3'd3, 3'd4, 3'd5: return 4'b0010;
      default:       return 4'b0001;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for a few cycles; returns 1 time unit after an edge with
  // reset just released (cycle 0 of the scenario).
  task automatic apply_reset();
    rst = 1'b1;
    link.trg_tx_pll_lock = 1'b0;
    link.trg_txresetdone = 1'b0;
    link.tx_sync_done    = 1'b0;
    link.link_restart    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = (link.state === s);
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      ok = (link.state === s);
    end
  endtask

  // With every status line already high, the link reaches UP after ~275 cycles.
  task automatic bring_up_fast(output bit ok);
    link.trg_tx_pll_lock = 1'b1;
    link.trg_txresetdone = 1'b1;
    link.tx_sync_done    = 1'b1;
    wait_state(3'd6, 400, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    link.trg_tx_pll_lock = 1'b1;
    link.trg_txresetdone = 1'b1;
    link.tx_sync_done    = 1'b1;
    link.link_restart    = 1'b0;
    repeat (4) tick();
    checks++;
    if (link.state !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got %0d expected 0", link.state);
    end
    checks++;
    if ({link.trg_tx_pllrst, link.trg_gtxtxrst, link.trg_rst, link.link_up} !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b expected 1110",
               {link.trg_tx_pllrst, link.trg_gtxtxrst, link.trg_rst, link.link_up});
    end
    checks++;
    if ({link.retry_cnt, link.timeout_err} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters: retry=%0d terr=%b expected 0/0",
               link.retry_cnt, link.timeout_err);
    end
  endtask

  // Lock at cycle 20, reset-done at 40, sync at 60. Synchronizer latency puts
  // GTX_RST at 23, RSTDONE_WAIT at 31, SYNC_WAIT at 43, COMMA at 61, UP at 317.
  task automatic test_bring_up();
    int          cp_cyc[12] = '{7, 8, 22, 23, 30, 31, 42, 43, 60, 61, 316, 317};
    logic [2:0]  cp_st[12]  = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6};
    logic [3:0]  outs;
    int          k = 0;
    int          p0;
    apply_reset();
    p0 = terr_pulses;
    for (int cyc = 1; cyc <= 317; cyc++) begin
      tick();
      if (k < 12 && cyc == cp_cyc[k]) begin
        checks++;
        if (link.state !== cp_st[k]) begin
          failures++;
          $display("[TB] FAIL bringup_state@%0d: got %0d expected %0d", cyc, link.state, cp_st[k]);
        end
        outs = {link.trg_tx_pllrst, link.trg_gtxtxrst, link.trg_rst, link.link_up};
        checks++;
        if (outs !== exp_outputs(cp_st[k])) begin
          failures++;
          $display("[TB] FAIL bringup_outputs@%0d: got %b expected %b", cyc, outs, exp_outputs(cp_st[k]));
        end
        k++;
      end
      if (cyc == 20) link.trg_tx_pll_lock = 1'b1;
      if (cyc == 40) link.trg_txresetdone = 1'b1;
      if (cyc == 60) link.tx_sync_done    = 1'b1;
    end
    checks++;
    if (link.retry_cnt !== 8'd0 || terr_pulses != p0) begin
      failures++;
      $display("[TB] FAIL bringup_retry: retry=%0d pulses=%0d expected 0/0",
               link.retry_cnt, terr_pulses - p0);
    end
  endtask

  // No lock ever: PLL_WAIT entered at 8, times out at 108, 216, 324.
  task automatic test_timeout();
    int p0;
    apply_reset();
    p0 = terr_pulses;
    for (int cyc = 1; cyc <= 330; cyc++) begin
      tick();
      if (cyc == 107) begin
        checks++;
        if (link.state !== 3'd1 || link.timeout_err !== 1'b0 || link.retry_cnt !== 8'd0) begin
          failures++;
          $display("[TB] FAIL timeout_before: state=%0d terr=%b retry=%0d expected 1/0/0",
                   link.state, link.timeout_err, link.retry_cnt);
        end
      end
      if (cyc == 108) begin
        checks++;
        if (link.state !== 3'd0 || link.timeout_err !== 1'b1 || link.retry_cnt !== 8'd1 ||
            link.trg_tx_pllrst !== 1'b1) begin
          failures++;
          $display("[TB] FAIL timeout_first: state=%0d terr=%b retry=%0d pllrst=%b expected 0/1/1/1",
                   link.state, link.timeout_err, link.retry_cnt, link.trg_tx_pllrst);
        end
      end
      if (cyc == 109) begin
        checks++;
        if (link.timeout_err !== 1'b0) begin
          failures++;
          $display("[TB] FAIL timeout_pulse_width: got %b expected 0", link.timeout_err);
        end
      end
      if (cyc == 116) begin
        checks++;
        if (link.state !== 3'd1) begin
          failures++;
          $display("[TB] FAIL timeout_rewait: got %0d expected 1", link.state);
        end
      end
      if (cyc == 216) begin
        checks++;
        if (link.timeout_err !== 1'b1 || link.retry_cnt !== 8'd2) begin
          failures++;
          $display("[TB] FAIL timeout_second: terr=%b retry=%0d expected 1/2",
                   link.timeout_err, link.retry_cnt);
        end
      end
    end
    checks++;
    if (terr_pulses - p0 != 3 || link.retry_cnt !== 8'd3) begin
      failures++;
      $display("[TB] FAIL timeout_count: pulses=%0d retry=%0d expected 3/3",
               terr_pulses - p0, link.retry_cnt);
    end
  endtask

  // One-cycle lock drop in UP: two synchronizer flops then the FSM reacts.
  task automatic test_lock_loss_up();
    bit ok;
    int p0;
    apply_reset();
    bring_up_fast(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL lockloss_reach_up: state=%0d expected 6", link.state);
    end
    p0 = terr_pulses;
    link.trg_tx_pll_lock = 1'b0;
    tick();
    link.trg_tx_pll_lock = 1'b1;
    tick();
    checks++;
    if (link.state !== 3'd6) begin
      failures++;
      $display("[TB] FAIL lockloss_latency: got %0d expected 6", link.state);
    end
    tick();
    checks++;
    if (link.state !== 3'd0 || link.link_up !== 1'b0 || link.trg_rst !== 1'b1 ||
        link.retry_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL lockloss_result: state=%0d up=%b trg_rst=%b retry=%0d expected 0/0/1/1",
               link.state, link.link_up, link.trg_rst, link.retry_cnt);
    end
    repeat (3) tick();
    checks++;
    if (terr_pulses != p0) begin
      failures++;
      $display("[TB] FAIL lockloss_no_timeout: pulses=%0d expected 0", terr_pulses - p0);
    end
  endtask

  // Restart request and synchronized lock loss land on the same edge in COMMA.
  task automatic test_coincidence();
    bit ok;
    apply_reset();
    link.trg_tx_pll_lock = 1'b1;
    link.trg_txresetdone = 1'b1;
    link.tx_sync_done    = 1'b1;
    wait_state(3'd5, 100, ok);
    link.trg_tx_pll_lock = 1'b0;
    tick();
    tick();
    checks++;
    if (!ok || link.state !== 3'd5) begin
      failures++;
      $display("[TB] FAIL coinc_in_comma: state=%0d expected 5", link.state);
    end
    link.link_restart = 1'b1;
    tick();
    link.link_restart = 1'b0;
    checks++;
    if (link.state !== 3'd0 || link.retry_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL coinc_result: state=%0d retry=%0d expected 0/1",
               link.state, link.retry_cnt);
    end
    repeat (4) tick();
    checks++;
    if (link.retry_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL coinc_single_inc: got %0d expected 1", link.retry_cnt);
    end
  endtask

  // Restart at cycle 3 of PLL_RST restarts the 8-cycle hold without a retry.
  task automatic test_restart_in_pll_rst();
    apply_reset();
    repeat (3) tick();
    link.link_restart = 1'b1;
    tick();
    link.link_restart = 1'b0;
    repeat (7) tick();
    checks++;
    if (link.state !== 3'd0 || link.retry_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL pllrst_restart_hold: state=%0d retry=%0d expected 0/0",
               link.state, link.retry_cnt);
    end
    tick();
    checks++;
    if (link.state !== 3'd1) begin
      failures++;
      $display("[TB] FAIL pllrst_restart_exit: got %0d expected 1", link.state);
    end
  endtask

  // 300 restarts from PLL_WAIT; the counter must stick at 255.
  task automatic test_saturation();
    bit ok;
    bit stalled = 1'b0;
    apply_reset();
    for (int i = 0; i < 300 && !stalled; i++) begin
      wait_state(3'd1, 20, ok);
      if (!ok) begin
        stalled = 1'b1;
      end else begin
        link.link_restart = 1'b1;
        tick();
        link.link_restart = 1'b0;
        if (i == 254) begin
          checks++;
          if (link.retry_cnt !== 8'd255) begin
            failures++;
            $display("[TB] FAIL sat_reach: got %0d expected 255", link.retry_cnt);
          end
        end
      end
    end
    checks++;
    if (stalled || link.retry_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL sat_hold: retry=%0d stalled=%b expected 255/0", link.retry_cnt, stalled);
    end
  endtask

  // Reset raised between edges while UP must take effect immediately.
  task automatic test_async_reset();
    bit ok;
    apply_reset();
    bring_up_fast(ok);
    checks++;
    if (!ok || link.link_up !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reach_up: state=%0d up=%b expected 6/1", link.state, link.link_up);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({link.trg_tx_pllrst, link.trg_gtxtxrst, link.trg_rst, link.link_up} !== 4'b1110 ||
        link.state !== 3'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: outs=%b state=%0d expected 1110/0",
               {link.trg_tx_pllrst, link.trg_gtxtxrst, link.trg_rst, link.link_up}, link.state);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    link.trg_tx_pll_lock = 1'b0;
    link.trg_txresetdone = 1'b0;
    link.tx_sync_done    = 1'b0;
    link.link_restart    = 1'b0;
    test_reset();
    test_bring_up();
    test_timeout();
    test_lock_loss_up();
    test_coincidence();
    test_restart_in_pll_rst();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trg_tx_link_ctrl.md
TRG_TX_LINK_CTRL -- requirements
Module: trg_tx_link_ctrl

Interface
REQ-001 Parameter PLLRST_CYCLES, default 8: cycles the TX PLL reset is held.
REQ-002 Parameter GTXRST_CYCLES, default 8: cycles the GTX TX reset is held after PLL lock.
REQ-003 Parameter COMMA_CYCLES, default 256: idle-comma cycles sent before data is enabled.
REQ-004 Parameter WAIT_TIMEOUT, default 65535: maximum cycles spent in any wait state.
REQ-005 TRG_CLK80  in  1  the only clock; all logic is on its rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 TRG_TX_PLL_LOCK  in  1  GTX TX PLL lock; asynchronous to TRG_CLK80.
REQ-008 TRG_TXRESETDONE  in  1  GTX TX reset done; asynchronous to TRG_CLK80.
REQ-009 TX_SYNC_DONE  in  1  TX phase-alignment done; synchronous to TRG_CLK80.
REQ-010 LINK_RESTART  in  1  one-cycle request to re-run the full bring-up.
REQ-011 TRG_TX_PLLRST  out  1  TX PLL reset to the transmitter.
REQ-012 TRG_GTXTXRST  out  1  GTX TX reset to the transmitter.
REQ-013 TRG_RST  out  1  forces the transmitter to send commas and holds its frame counter and PRBS in reset.
REQ-014 LINK_UP  out  1  high while user data is on the fiber.
REQ-015 STATE  out  3  current state encoding.
REQ-016 RETRY_CNT  out  8  number of bring-up restarts; saturates at 255.
REQ-017 TIMEOUT_ERR  out  1  one-cycle pulse when a wait state times out.

Function
REQ-018 Two-flop synchronizers SHALL be applied to TRG_TX_PLL_LOCK and TRG_TXRESETDONE; the FSM SHALL use only the synchronized values, which add 2 cycles of latency.
REQ-019 State encodings SHALL be: PLL_RST=0, PLL_WAIT=1, GTX_RST=2, RSTDONE_WAIT=3, SYNC_WAIT=4, COMMA=5, UP=6.
REQ-020 A 16-bit state timer SHALL clear to 0 on every state entry and increment each cycle while in a state.
REQ-021 PLL_RST: the FSM SHALL remain in this state for exactly PLLRST_CYCLES cycles, then go to PLL_WAIT.
REQ-022 PLL_WAIT: on synchronized lock high, go to GTX_RST.
REQ-023 GTX_RST: remain for exactly GTXRST_CYCLES cycles, then go to RSTDONE_WAIT.
REQ-024 RSTDONE_WAIT: on synchronized reset-done high, go to SYNC_WAIT.
REQ-025 SYNC_WAIT: on TX_SYNC_DONE high, go to COMMA.
REQ-026 COMMA: remain for exactly COMMA_CYCLES cycles, then go to UP.
REQ-027 Outputs SHALL be registered and decoded from the state: TRG_TX_PLLRST=1 only in PLL_RST; TRG_GTXTXRST=1 in PLL_RST, PLL_WAIT and GTX_RST; TRG_RST=1 in every state except UP; LINK_UP=1 only in UP.
REQ-028 Timeout: in PLL_WAIT, RSTDONE_WAIT or SYNC_WAIT, when the timer reaches WAIT_TIMEOUT with the exit condition still false, the FSM SHALL go to PLL_RST, pulse TIMEOUT_ERR for one cycle and increment RETRY_CNT.
REQ-029 In GTX_RST through UP, a loss of synchronized lock SHALL send the FSM to PLL_RST and increment RETRY_CNT; TIMEOUT_ERR SHALL NOT pulse.
REQ-030 In UP, a loss of synchronized reset-done SHALL send the FSM to PLL_RST and increment RETRY_CNT.
REQ-031 LINK_RESTART in any state other than PLL_RST SHALL send the FSM to PLL_RST and increment RETRY_CNT; in PLL_RST it SHALL restart the hold timer.
REQ-032 Priority when events coincide: LINK_RESTART > lock loss > timeout > normal exit; RETRY_CNT SHALL increment at most once per cycle.
REQ-033 RETRY_CNT SHALL saturate at 255 and never wrap.

Reset
REQ-034 While RST is high, and on its deassertion: STATE=PLL_RST, timer=0, synchronizers=0, TRG_TX_PLLRST=1, TRG_GTXTXRST=1, TRG_RST=1, LINK_UP=0, TIMEOUT_ERR=0, RETRY_CNT=0.
REQ-035 RST asserted mid-operation SHALL return all outputs to their REQ-034 values immediately, without waiting for a clock edge.

Verification
REQ-036 Normal bring-up: release RST; raise lock at cycle 20, reset-done at cycle 40, TX_SYNC_DONE at cycle 60 -> states step 0,1,2,3,4,5,6; LINK_UP rises exactly 256 cycles after COMMA entry; RETRY_CNT=0.
REQ-037 Timeout (WAIT_TIMEOUT=100): never raise lock -> TIMEOUT_ERR pulses once per 8+100 cycles after entering PLL_WAIT; RETRY_CNT increments each time; TRG_TX_PLLRST reasserts.
REQ-038 Lock loss in UP: drop lock for 1 cycle -> state 0 within 3 cycles; LINK_UP=0 and TRG_RST=1; RETRY_CNT=1; no TIMEOUT_ERR.
REQ-039 Coincidence: LINK_RESTART and lock loss in the same cycle in COMMA -> state 0; RETRY_CNT incremented by exactly 1.
REQ-040 Saturation: force 300 restarts -> RETRY_CNT=255.
REQ-041 Async reset: assert RST mid-clock while in UP -> LINK_UP=0 and all resets=1 before the next edge.
